panel_input_decoder: RTL and testbench

//   Consumes the 24 parallel bits latched by the front-panel shift-register controller once per

---
 rtl/panel_input_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_panel_input_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/panel_input_decoder.sv
// evt_fifo: small first-word-fall-through FIFO with valid/ready output handshake.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: pushes are dropped only when full and not popping; the writer should gate on full.
module evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         full,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];
    assign do_pop  = pop_vld & pop_rdy;
    // A full FIFO may still take a word in the same cycle one leaves.
    assign do_push = push_vld & (~full | do_pop);

    // Storage array; no reset needed since contents are qualified by count.
    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// panel_input_decoder: debounces buttons, decodes quadrature encoders, queues change events.
// Latency: BTN_STATE/ENC_POS update 1 cycle after FRAME_VALID; event reaches EVT_VALID 2 cycles after.
// Backpressure: EVT_READY low fills the FIFO, then per-source pending flags hold; a re-hit flag sets EVT_OVF.
module panel_input_decoder #(
    parameter int N_BITS     = 24,
    parameter int N_ENC      = 4,
    parameter int DEB_FRAMES = 4,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     CLK_IN,
    input  logic                     RST_N,
    input  logic                     FRAME_VALID,
    input  logic [N_BITS-1:0]        IN_BITS,
    output logic [N_BITS-2*N_ENC-1:0] BTN_STATE,
    output logic [N_ENC*CNT_W-1:0]   ENC_POS,
    output logic                     EVT_VALID,
    output logic [7:0]               EVT_DATA,
    input  logic                     EVT_READY,
    output logic                     EVT_OVF,
    input  logic                     CLR_OVF
);
    localparam int NB = N_BITS - 2*N_ENC;
    localparam int NS = NB + N_ENC;          // sources: encoders first, then buttons
    localparam int DW = $clog2(DEB_FRAMES + 1);
    localparam int SW = $clog2(NS);

    logic [NB-1:0]    btn_state;
    logic [DW-1:0]    btn_cnt [NB];
    logic [1:0]       enc_prev [N_ENC];
    logic [N_ENC-1:0] enc_primed;
    logic [CNT_W-1:0] enc_pos [N_ENC];
    logic [N_ENC-1:0] enc_inc;
    logic [N_ENC-1:0] enc_dec;

    logic [NS-1:0]    pend;
    logic [NS-1:0]    pend_dir;
    logic [NS-1:0]    ev_set;
    logic [NS-1:0]    ev_dir;
    logic [NS-1:0]    scan_clr;
    logic             scan_hit;
    logic [SW-1:0]    scan_idx;
    logic             push_vld;
    logic [7:0]       push_dat;
    logic             fifo_full;
    logic             ovf_set;
    logic             evt_ovf;

    // Map {B,A} gray code to a 2-bit position so steps become a modular difference.
    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // Per-frame event detection for buttons about to flip and encoders that stepped.
    always_comb begin
        ev_set  = '0;
        ev_dir  = '0;
        enc_inc = '0;
        enc_dec = '0;
        for (int i = 0; i < NB; i++) begin
            if (FRAME_VALID && (IN_BITS[2*N_ENC+i] != btn_state[i]) &&
                (btn_cnt[i] == DW'(DEB_FRAMES - 1))) begin
                ev_set[N_ENC+i] = 1'b1;
                ev_dir[N_ENC+i] = IN_BITS[2*N_ENC+i];
            end
        end
        for (int k = 0; k < N_ENC; k++) begin
            logic [1:0] d;
            d = gray2bin(IN_BITS[2*k +: 2]) - gray2bin(enc_prev[k]);
            if (FRAME_VALID && enc_primed[k]) begin
                // d==2 means both bits moved: direction unknown, drop it.
                if (d == 2'd1) begin
                    enc_inc[k] = 1'b1;
                    ev_set[k]  = 1'b1;
                    ev_dir[k]  = 1'b1;
                end else if (d == 2'd3) begin
                    enc_dec[k] = 1'b1;
                    ev_set[k]  = 1'b1;
                end
            end
        end
    end

    // Priority scan: lowest-indexed pending source wins (encoders occupy the low indices).
    always_comb begin
        scan_hit = |pend;
        scan_idx = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if (pend[s]) scan_idx = SW'(s);
        end
        push_vld = scan_hit & ~fifo_full;
        scan_clr = '0;
        if (push_vld) scan_clr[scan_idx] = 1'b1;
        if (int'(scan_idx) < N_ENC)
            push_dat = {1'b1, pend_dir[scan_idx], 1'b0, 5'(scan_idx)};
        else
            push_dat = {1'b0, pend_dir[scan_idx], 1'b0, 5'(int'(scan_idx) - N_ENC)};
        // An event landing on a flag being pushed this cycle loses nothing.
        ovf_set = |(ev_set & pend & ~scan_clr);
    end

    // Button debounce: count consecutive differing frames, flip on the DEB_FRAMES-th.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            btn_state <= '0;
            for (int i = 0; i < NB; i++) btn_cnt[i] <= '0;
        end else if (FRAME_VALID) begin
            for (int i = 0; i < NB; i++) begin
                if (IN_BITS[2*N_ENC+i] == btn_state[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_cnt[i] == DW'(DEB_FRAMES - 1)) begin
                    btn_state[i] <= ~btn_state[i];
                    btn_cnt[i]   <= '0;
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Encoder tracking: first frame only primes prev; counters wrap modulo 2^CNT_W.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            enc_primed <= '0;
            for (int k = 0; k < N_ENC; k++) begin
                enc_prev[k] <= '0;
                enc_pos[k]  <= '0;
            end
        end else if (FRAME_VALID) begin
            enc_primed <= '1;
            for (int k = 0; k < N_ENC; k++) begin
                enc_prev[k] <= IN_BITS[2*k +: 2];
                if (enc_inc[k])      enc_pos[k] <= enc_pos[k] + 1'b1;
                else if (enc_dec[k]) enc_pos[k] <= enc_pos[k] - 1'b1;
            end
        end
    end

    // Pending flags: new events set (newest direction wins), scanner pushes clear.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            pend     <= '0;
            pend_dir <= '0;
            evt_ovf  <= 1'b0;
        end else begin
            pend     <= (pend & ~scan_clr) | ev_set;
            pend_dir <= (pend_dir & ~ev_set) | (ev_dir & ev_set);
            if (ovf_set)      evt_ovf <= 1'b1;
            else if (CLR_OVF) evt_ovf <= 1'b0;
        end
    end

    evt_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_evt_fifo (
        .core_clk (CLK_IN),
        .arst_n   (RST_N),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .full     (fifo_full),
        .pop_vld  (EVT_VALID),
        .pop_rdy  (EVT_READY),
        .pop_dat  (EVT_DATA)
    );

    assign BTN_STATE = btn_state;
    assign EVT_OVF   = evt_ovf;

    for (genvar k = 0; k < N_ENC; k++) begin : g_pos
        assign ENC_POS[k*CNT_W +: CNT_W] = enc_pos[k];
    end
endmodule

// File: tb/tb_panel_input_decoder.sv
// Directed bench for panel_input_decoder: debounce, encoder decode, event ordering, overflow, reset.
// Inputs change 2ns after the rising edge; outputs are checked away from the edge.
// Popped events are logged on the falling edge whenever EVT_VALID and EVT_READY are both high.
module tb_panel_input_decoder;
    logic        CLK_IN = 1'b0;
    logic        RST_N;
    logic        FRAME_VALID;
    logic [23:0] IN_BITS;
    logic [15:0] BTN_STATE;
    logic [31:0] ENC_POS;
    logic        EVT_VALID;
    logic [7:0]  EVT_DATA;
    logic        EVT_READY;
    logic        EVT_OVF;
    logic        CLR_OVF;

    int checks   = 0;
    int failures = 0;
    logic [23:0] cur = '0;
    logic [7:0]  q [$];

    panel_input_decoder dut (
        .CLK_IN      (CLK_IN),
        .RST_N       (RST_N),
        .FRAME_VALID (FRAME_VALID),
        .IN_BITS     (IN_BITS),
        .BTN_STATE   (BTN_STATE),
        .ENC_POS     (ENC_POS),
        .EVT_VALID   (EVT_VALID),
        .EVT_DATA    (EVT_DATA),
        .EVT_READY   (EVT_READY),
        .EVT_OVF     (EVT_OVF),
        .CLR_OVF     (CLR_OVF)
    );

    always #5 CLK_IN = ~CLK_IN;

    always @(negedge CLK_IN) begin
        if (RST_N && EVT_VALID && EVT_READY) q.push_back(EVT_DATA);
    end

    function automatic logic [1:0] next_cw(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK_IN);
        #2;
    endtask

    // One frame of cur; returns 2ns after the capturing edge.
    task automatic frame(input logic clr);
        @(posedge CLK_IN); #2;
        IN_BITS = cur; FRAME_VALID = 1'b1; CLR_OVF = clr;
        @(posedge CLK_IN); #2;
        FRAME_VALID = 1'b0; CLR_OVF = 1'b0;
    endtask

    task automatic enc_step(input int k);
        cur[2*k +: 2] = next_cw(cur[2*k +: 2]);
        frame(1'b0);
    endtask

    task automatic clr_pulse();
        @(posedge CLK_IN); #2; CLR_OVF = 1'b1;
        @(posedge CLK_IN); #2; CLR_OVF = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; FRAME_VALID = 1'b0; IN_BITS = '0; EVT_READY = 1'b0; CLR_OVF = 1'b0;
        repeat (3) @(posedge CLK_IN);
        #2;
        checks++; if (BTN_STATE !== 16'h0) begin failures++; $display("FAIL reset_btn got=%h exp=0000", BTN_STATE); end
        checks++; if (ENC_POS !== 32'h0) begin failures++; $display("FAIL reset_pos got=%h exp=00000000", ENC_POS); end
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", EVT_VALID); end
        checks++; if (EVT_OVF !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", EVT_OVF); end
        RST_N = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_encoder();
        int bad;
        EVT_READY = 1'b1;
        q.delete();
        cur[3:2] = 2'b01;
        frame(1'b0);
        checks++; if (ENC_POS[15:8] !== 8'd0) begin failures++; $display("FAIL enc_prime got=%h exp=00", ENC_POS[15:8]); end
        enc_step(1); enc_step(1); enc_step(1);
        checks++; if (ENC_POS[15:8] !== 8'd3) begin failures++; $display("FAIL enc_cw3 got=%h exp=03", ENC_POS[15:8]); end
        checks++; if (ENC_POS[7:0] !== 8'd0) begin failures++; $display("FAIL enc0_idle got=%h exp=00", ENC_POS[7:0]); end
        wait_cyc(6);
        checks++; if (q.size() !== 3) begin failures++; $display("FAIL enc_evt_cnt got=%0d exp=3", q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) begin
                checks++; if (q[i] !== 8'hC1) begin failures++; $display("FAIL enc_evt_%0d got=%h exp=c1", i, q[i]); end
            end
        end
        cur[3:2] = 2'b11;   // 00 -> 11: both bits changed
        frame(1'b0);
        checks++; if (ENC_POS[15:8] !== 8'd3) begin failures++; $display("FAIL enc_invalid got=%h exp=03", ENC_POS[15:8]); end
        wait_cyc(4);
        checks++; if (q.size() !== 3) begin failures++; $display("FAIL enc_invalid_evt got=%0d exp=3", q.size()); end
        q.delete();
        repeat (124) enc_step(1);
        checks++; if (ENC_POS[15:8] !== 8'h7F) begin failures++; $display("FAIL enc_127 got=%h exp=7f", ENC_POS[15:8]); end
        enc_step(1);
        checks++; if (ENC_POS[15:8] !== 8'h80) begin failures++; $display("FAIL enc_wrap got=%h exp=80", ENC_POS[15:8]); end
        wait_cyc(6);
        bad = 0;
        foreach (q[i]) if (q[i] !== 8'hC1) bad++;
        checks++; if (q.size() !== 125 || bad != 0) begin failures++; $display("FAIL enc_wrap_evts got=%0d/%0d_bad exp=125/0", q.size(), bad); end
        checks++; if (EVT_OVF !== 1'b0) begin failures++; $display("FAIL enc_wrap_ovf got=%b exp=0", EVT_OVF); end
    endtask

    task automatic test_btn_short();
        q.delete();
        cur[8] = 1'b1;
        repeat (3) frame(1'b0);
        cur[8] = 1'b0;
        frame(1'b0);
        checks++; if (BTN_STATE !== 16'h0) begin failures++; $display("FAIL btn_short got=%h exp=0000", BTN_STATE); end
        wait_cyc(6);
        checks++; if (q.size() !== 0 || EVT_VALID !== 1'b0) begin failures++; $display("FAIL btn_short_evt got=%0d exp=0", q.size()); end
    endtask

    task automatic test_btn_press();
        q.delete();
        cur[8] = 1'b1;
        repeat (3) frame(1'b0);
        checks++; if (BTN_STATE[0] !== 1'b0) begin failures++; $display("FAIL btn_3rd got=%b exp=0", BTN_STATE[0]); end
        frame(1'b0);
        checks++; if (BTN_STATE !== 16'h0001) begin failures++; $display("FAIL btn_4th got=%h exp=0001", BTN_STATE); end
        wait_cyc(6);
        checks++; if (q.size() !== 1) begin failures++; $display("FAIL btn_evt_cnt got=%0d exp=1", q.size()); end
        else begin
            checks++; if (q[0] !== 8'h40) begin failures++; $display("FAIL btn_evt got=%h exp=40", q[0]); end
        end
    endtask

    task automatic test_toggle_all();
        logic [7:0] exp;
        q.delete();
        EVT_READY = 1'b0;
        cur[23:8] = 16'hFFFE;
        repeat (4) frame(1'b0);
        checks++; if (BTN_STATE !== 16'hFFFE) begin failures++; $display("FAIL tog_state got=%h exp=fffe", BTN_STATE); end
        wait_cyc(12);
        checks++; if (EVT_VALID !== 1'b1 || EVT_DATA !== 8'h00) begin failures++; $display("FAIL tog_head got=%b/%h exp=1/00", EVT_VALID, EVT_DATA); end
        wait_cyc(3);
        checks++; if (EVT_DATA !== 8'h00) begin failures++; $display("FAIL tog_stable got=%h exp=00", EVT_DATA); end
        EVT_READY = 1'b1;
        wait_cyc(30);
        checks++; if (q.size() !== 16) begin failures++; $display("FAIL tog_cnt got=%0d exp=16", q.size()); end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 0) ? 8'h00 : (8'h40 | 8'(i));
            if (i < q.size()) begin
                checks++; if (q[i] !== exp) begin failures++; $display("FAIL tog_order_%0d got=%h exp=%h", i, q[i], exp); end
            end
        end
        checks++; if (EVT_OVF !== 1'b0) begin failures++; $display("FAIL tog_ovf got=%b exp=0", EVT_OVF); end
    endtask

    task automatic test_overflow();
        EVT_READY = 1'b0;
        repeat (8) enc_step(0);
        wait_cyc(3);
        checks++; if (EVT_OVF !== 1'b0) begin failures++; $display("FAIL ovf_fill got=%b exp=0", EVT_OVF); end
        enc_step(0);   // FIFO full: held in pending flag
        wait_cyc(2);
        checks++; if (EVT_OVF !== 1'b0) begin failures++; $display("FAIL ovf_pend got=%b exp=0", EVT_OVF); end
        enc_step(0);   // overwrites pending flag
        checks++; if (EVT_OVF !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", EVT_OVF); end
        clr_pulse();
        checks++; if (EVT_OVF !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", EVT_OVF); end
        cur[1:0] = next_cw(cur[1:0]);
        frame(1'b1);   // overflow and clear together
        checks++; if (EVT_OVF !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", EVT_OVF); end
        clr_pulse();
        checks++; if (EVT_OVF !== 1'b0) begin failures++; $display("FAIL ovf_clr2 got=%b exp=0", EVT_OVF); end
        checks++; if (ENC_POS[7:0] !== 8'd11) begin failures++; $display("FAIL ovf_pos got=%h exp=0b", ENC_POS[7:0]); end
        checks++; if (EVT_DATA !== 8'hC0) begin failures++; $display("FAIL ovf_head got=%h exp=c0", EVT_DATA); end
    endtask

    task automatic test_reset_mid();
        EVT_READY = 1'b1;
        wait_cyc(2);
        checks++; if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL mid_draining got=%b exp=1", EVT_VALID); end
        #1 RST_N = 1'b0;
        #1;
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", EVT_VALID); end
        checks++; if (ENC_POS !== 32'h0) begin failures++; $display("FAIL mid_pos got=%h exp=00000000", ENC_POS); end
        checks++; if (BTN_STATE !== 16'h0) begin failures++; $display("FAIL mid_btn got=%h exp=0000", BTN_STATE); end
        wait_cyc(2);
        RST_N = 1'b1;
        wait_cyc(5);
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL mid_after got=%b exp=0", EVT_VALID); end
    endtask

    initial begin
        test_reset();
        test_encoder();
        test_btn_short();
        test_btn_press();
        test_toggle_all();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
